ccff_loader: RTL and testbench



---
 rtl/ccff_pkg.sv | 17 +
 rtl/ccff_capture.sv | 73 +++++++
 rtl/ccff_loader.sv | 193 +++++++++++++++++++
 tb/tb_ccff_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// ccff_pkg: shared definitions for the configuration-chain loader.
//   - ccff_ld_state_e : loader FSM state encoding
//   - CCFF_WORD_W     : default bitstream word width
//   - CCFF_LEN_W      : default chain length counter width
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ccff_ld_state_e;

    localparam int CCFF_WORD_W = 32;
    localparam int CCFF_LEN_W  = 20;

endpackage

// File: rtl/ccff_capture.sv
// ccff_capture: readback deserialiser for bits emerging at ccff_tail.
// Collects one bit per sample (first-captured bit ends in the MSB) and
// presents a word after WORD_W samples or at the final chain bit; a partial
// word is left-aligned and zero-padded.
// Ports:
//   prog_clk, pReset_n : clock, async active-low reset
//   clear              : drop any partial capture (new load accepted)
//   sample             : ccff_tail is valid and must be captured this cycle
//   last               : this sample is the final chain bit
//   tail               : serial bit from the chain
//   rdata, rvalid      : captured word and valid flag (held until rready)
//   rready             : consumer accepts rdata
module ccff_capture
    import ccff_pkg::*;
#(
    parameter int WORD_W = CCFF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              clear,
    input  logic              sample,
    input  logic              last,
    input  logic              tail,
    input  logic              rready,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] cap_r;
    logic [WORD_W-1:0] cap_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;

    // Capture register and sample count after taking the current bit.
    always_comb begin
        cap_next_s = {cap_r[WORD_W-2:0], tail};
        cnt_next_s = cnt_r + CNT_W'(1);
    end

    // Shift-in, word completion and readback handshake.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            cap_r  <= '0;
            cnt_r  <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else if (clear) begin
            cap_r  <= '0;
            cnt_r  <= '0;
            rvalid <= 1'b0;
        end else begin
            if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
            // The loader never samples while a word is pending, so a new
            // word can never overwrite an unconsumed one.
            if (sample) begin
                if ((cnt_next_s == CNT_W'(WORD_W)) || last) begin
                    rdata  <= cap_next_s << (CNT_W'(WORD_W) - cnt_next_s);
                    rvalid <= 1'b1;
                    cap_r  <= '0;
                    cnt_r  <= '0;
                end else begin
                    cap_r <= cap_next_s;
                    cnt_r <= cnt_next_s;
                end
            end
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// ccff_loader: serialises bitstream words onto the configuration flip-flop
// chain, MSB first, one bit per chain_clk_en cycle, for exactly chain_len bits,
// and keeps the pads isolated (io_isol_n=0) until a load completes.
// Optional feature macro: CCFF_READBACK_EN captures the old chain contents
// from ccff_tail into rdata/rvalid, stalling the chain while a word is pending.
// Ports:
//   prog_clk, pReset_n        : clock, async active-low reset
//   start, chain_len          : load request and length (sampled in IDLE)
//   busy, done                : load in progress / one-cycle completion pulse
//   wdata, wvalid, wready     : bitstream word stream
//   ccff_head, chain_clk_en   : serial bit into the chain and its enable
//   ccff_tail                 : serial bit out of the chain
//   io_isol_n                 : low while pads are isolated
//   rdata, rvalid, rready     : readback word stream (tied 0 when disabled)
module ccff_loader
    import ccff_pkg::*;
#(
    parameter int WORD_W = CCFF_WORD_W,
    parameter int LEN_W  = CCFF_LEN_W
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  chain_len,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    input  logic              ccff_tail,
    output logic              io_isol_n,
    output logic [WORD_W-1:0] rdata,
    output logic              rvalid,
    input  logic              rready
);

    localparam int WCNT_W = $clog2(WORD_W);

    ccff_ld_state_e    state_r;
    logic [LEN_W-1:0]  rem_r;       // bits not yet presented on ccff_head
    logic [WORD_W-1:0] sreg_r;      // unsent bits of the current word, left-aligned
    logic [WCNT_W-1:0] wbits_r;     // unsent bits left in the current word
    logic              chain_en_r;
    logic              wready_r;
    logic              head_r;
    logic              busy_r;
    logic              done_r;
    logic              isol_n_r;

    logic              stall_s;
    logic              adv_s;
    logic              whs_s;
    logic              start_acc_s;
    logic              rb_pending_s;
    logic              rb_clear_s;

`ifdef CCFF_READBACK_EN
    logic rvalid_s;
    logic rb_last_s;

    assign rb_last_s    = (rem_r == '0);
    // A pending unconsumed readback word blocks the next sample.
    assign stall_s      = chain_en_r & rvalid_s & ~rready;
    assign rb_pending_s = 1'b1;
    assign rb_clear_s   = ~rvalid_s | rready;
    assign rvalid       = rvalid_s;

    ccff_capture #(.WORD_W(WORD_W)) u_capture (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .clear    (start_acc_s),
        .sample   (adv_s),
        .last     (rb_last_s),
        .tail     (ccff_tail),
        .rready   (rready),
        .rdata    (rdata),
        .rvalid   (rvalid_s)
    );
`else
    logic unused_s;

    assign stall_s      = 1'b0;
    assign rb_pending_s = 1'b0;
    assign rb_clear_s   = 1'b1;
    assign rdata        = '0;
    assign rvalid       = 1'b0;
    assign unused_s     = rready ^ ccff_tail;
`endif

    assign adv_s        = chain_en_r & ~stall_s;
    assign whs_s        = wvalid & wready;
    assign start_acc_s  = start & (state_r == IDLE);

    assign chain_clk_en = adv_s;
    assign wready       = wready_r & ~stall_s;
    assign ccff_head    = head_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign io_isol_n    = isol_n_r;

    // Loader FSM: word fetch, bit serialisation and completion.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_r    <= IDLE;
            rem_r      <= '0;
            sreg_r     <= '0;
            wbits_r    <= '0;
            chain_en_r <= 1'b0;
            wready_r   <= 1'b0;
            head_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            isol_n_r   <= 1'b0;   // a partially loaded chain stays isolated
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r   <= 1'b1;
                        isol_n_r <= 1'b0;
                        rem_r    <= chain_len;
                        if (chain_len == '0) begin
                            state_r  <= DONE;
                            done_r   <= 1'b1;
                            isol_n_r <= 1'b1;
                        end else begin
                            state_r  <= FETCH;
                            wready_r <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (whs_s) begin
                        state_r    <= SHIFT;
                        head_r     <= wdata[WORD_W-1];
                        sreg_r     <= {wdata[WORD_W-2:0], 1'b0};
                        wbits_r    <= WCNT_W'(WORD_W - 1);
                        rem_r      <= rem_r - LEN_W'(1);
                        chain_en_r <= 1'b1;
                        wready_r   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (adv_s) begin
                        if (rem_r == '0) begin
                            // Current bit is the last chain bit; leftover
                            // low bits of a partial word are discarded.
                            state_r    <= DONE;
                            chain_en_r <= 1'b0;
                            wready_r   <= 1'b0;
                            done_r     <= ~rb_pending_s;
                            isol_n_r   <= ~rb_pending_s;
                        end else if (wbits_r != '0) begin
                            head_r   <= sreg_r[WORD_W-1];
                            sreg_r   <= {sreg_r[WORD_W-2:0], 1'b0};
                            wbits_r  <= wbits_r - WCNT_W'(1);
                            rem_r    <= rem_r - LEN_W'(1);
                            // Offer the next word alongside the last bit of
                            // this one so a ready source leaves no bubble.
                            wready_r <= (wbits_r == WCNT_W'(1)) && (rem_r > LEN_W'(1));
                        end else if (whs_s) begin
                            head_r   <= wdata[WORD_W-1];
                            sreg_r   <= {wdata[WORD_W-2:0], 1'b0};
                            wbits_r  <= WCNT_W'(WORD_W - 1);
                            rem_r    <= rem_r - LEN_W'(1);
                            wready_r <= 1'b0;
                        end else begin
                            state_r    <= FETCH;
                            chain_en_r <= 1'b0;
                            wready_r   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (done_r) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (rb_clear_s) begin
                        done_r   <= 1'b1;
                        isol_n_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: self-checking bench for ccff_loader. A vector table drives
// complete loads; expected chain bits are queued at each word handshake and
// popped on every chain_clk_en cycle. Hand-written sequences cover reset
// mid-load and, when CCFF_READBACK_EN is defined, readback with a stalled
// consumer. A 40-bit model chain sits between ccff_head and ccff_tail.
module tb_ccff_loader;

    localparam int WORD_W = 32;
    localparam int LEN_W  = 20;

    typedef struct {
        int               len;
        logic [2:0][31:0] words;
        int               stall;
        int               exp_cyc;
        int               exp_words;
    } vec_t;

    logic              prog_clk = 1'b0;
    logic              pReset_n;
    logic              start;
    logic [LEN_W-1:0]  chain_len;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic              ccff_head;
    logic              chain_clk_en;
    logic              ccff_tail;
    logic              io_isol_n;
    logic [WORD_W-1:0] rdata;
    logic              rvalid;
    logic              rready;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          exp_q[$];
    logic [31:0] rexp_q[$];
    logic [39:0] chain_m = '0;
    vec_t        vecs[7];

    ccff_loader #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
        .prog_clk     (prog_clk),
        .pReset_n     (pReset_n),
        .start        (start),
        .chain_len    (chain_len),
        .busy         (busy),
        .done         (done),
        .wdata        (wdata),
        .wvalid       (wvalid),
        .wready       (wready),
        .ccff_head    (ccff_head),
        .chain_clk_en (chain_clk_en),
        .ccff_tail    (ccff_tail),
        .io_isol_n    (io_isol_n),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready)
    );

    always #5 prog_clk = ~prog_clk;

    // Model configuration chain: shifts on every enabled edge.
    assign ccff_tail = chain_m[39];
    always @(posedge prog_clk) begin
        if (chain_clk_en) chain_m <= {chain_m[38:0], ccff_head};
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int len, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input int stall, input int exp_cyc,
                                input int exp_words);
        vec_t v;
        v.len = len; v.words = {w2, w1, w0}; v.stall = stall;
        v.exp_cyc = exp_cyc; v.exp_words = exp_words;
        return v;
    endfunction

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_wready"}, wready, 0);
        check({nm, "_chain_clk_en"}, chain_clk_en, 0);
        check({nm, "_ccff_head"}, ccff_head, 0);
        check({nm, "_rvalid"}, rvalid, 0);
        check({nm, "_io_isol_n"}, io_isol_n, 0);
        check({nm, "_rdata"}, rdata, 0);
    endtask

    // One complete load; called right after a falling edge.
    task automatic run_load(input vec_t v, input string nm);
        int          widx, pushed, en_cnt, stall_left, exp_cyc, cyc;
        bit          got_done, prev_head;
        logic [39:0] exp_chain;
        widx = 0; pushed = 0; en_cnt = 0; stall_left = 0; got_done = 0; cyc = 0;
        exp_cyc = v.exp_cyc;
`ifdef CCFF_READBACK_EN
        if (v.len > 0) exp_cyc++;   // DONE waits one cycle for the last readback word
`endif
        exp_q.delete();
        exp_chain = chain_m;
        prev_head = ccff_head;
        rready = 1'b1; start = 1'b1; chain_len = LEN_W'(v.len);
        wvalid = 1'b1; wdata = v.words[0];
        while (!got_done && cyc < exp_cyc + 20) begin
            @(negedge prog_clk);
            cyc++;
            start = 1'b0;
            if (chain_clk_en) begin
                en_cnt++;
                if (exp_q.size() == 0) check({nm, "_extra_bit"}, 1, 0);
                else check({nm, "_bit"}, ccff_head, exp_q.pop_front());
            end else begin
                check({nm, "_head_hold"}, ccff_head, prev_head);
            end
            prev_head = ccff_head;
            if (wready) check({nm, "_wready_needed"}, pushed < v.len, 1);
            if (done) begin
                got_done = 1;
                check({nm, "_done_cycle"}, cyc, exp_cyc);
                check({nm, "_isol_at_done"}, io_isol_n, 1);
                check({nm, "_en_count"}, en_cnt, v.len);
                check({nm, "_words_used"}, widx, v.exp_words);
                check({nm, "_chain"}, chain_m, exp_chain);
            end else begin
                check({nm, "_busy"}, busy, 1);
                check({nm, "_isol_low"}, io_isol_n, 0);
                if (cyc == 3 && v.len >= 8) begin
                    start = 1'b1;                // must be ignored while busy
                    chain_len = LEN_W'(5);
                end
                wvalid = 1'b1;
                if (widx == 1 && stall_left > 0 && wready) begin
                    wvalid = 1'b0;
                    stall_left--;
                end
                wdata = (widx < 3) ? v.words[widx] : 32'hDEAD_BEEF;
                #1;
                if (wvalid && wready) begin
                    for (int b = 31; b >= 0; b--) begin
                        if (pushed < v.len) begin
                            exp_q.push_back(wdata[b]);
                            exp_chain = {exp_chain[38:0], wdata[b]};
                            pushed++;
                        end
                    end
                    widx++;
                    if (widx == 1) stall_left = v.stall;
                end
            end
        end
        if (!got_done) check({nm, "_done_timeout"}, 0, 1);
        wvalid = 1'b0; start = 1'b0;
        @(negedge prog_clk);
        check({nm, "_idle_busy"}, busy, 0);
        check({nm, "_idle_done"}, done, 0);
        check({nm, "_idle_isol"}, io_isol_n, 1);
        check({nm, "_idle_en"}, chain_clk_en, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en, cyc;
        pReset_n = 1'b0; start = 1'b0; chain_len = '0; wdata = '0; wvalid = 1'b0; rready = 1'b1;

        vecs[0] = mk(8,  32'hA53C_0FF0, 32'h0,          32'h0,          0, 10, 1);
        vecs[1] = mk(70, 32'h0F1E_2D3C, 32'h89AB_CDEF, 32'hB7FF_FFFF, 0, 72, 3);
        vecs[2] = mk(64, 32'hC3C3_A5A5, 32'h5A5A_3C3C, 32'h0,          5, 71, 2);
        vecs[3] = mk(0,  32'hFFFF_FFFF, 32'h0,          32'h0,          0, 1,  0);
        vecs[4] = mk(1,  32'h8000_0000, 32'h0,          32'h0,          0, 3,  1);
        vecs[5] = mk(33, 32'h1234_5678, 32'h8000_0001, 32'h0,          0, 35, 2);
        vecs[6] = mk(32, 32'h7FFF_FFFE, 32'h0,          32'h0,          0, 34, 1);

        // Reset state.
        repeat (2) @(negedge prog_clk);
        check_all_zero("reset");
        pReset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_load(vecs[i], $sformatf("vec%0d", i));
        end
`ifndef CCFF_READBACK_EN
        check("rb_off_rvalid", rvalid, 0);
        check("rb_off_rdata", rdata, 0);
`endif

        // Reset at bit 20 of a 40-bit load.
        start = 1'b1; chain_len = LEN_W'(40); wvalid = 1'b1; wdata = 32'hFFFF_FFFF;
        en = 0; cyc = 0;
        while (en < 20 && cyc < 60) begin
            @(negedge prog_clk);
            cyc++;
            start = 1'b0;
            if (chain_clk_en) en++;
        end
        check("rst_reach_bit20", en, 20);
        #2 pReset_n = 1'b0;
        #1 check_all_zero("rst_async");
        @(negedge prog_clk);
        check_all_zero("rst_held");
        wvalid = 1'b0;
        pReset_n = 1'b1;
        run_load(mk(40, 32'h3CA5_F00D, 32'hE100_0000, 32'h0, 0, 42, 2), "reload40");

`ifdef CCFF_READBACK_EN
        // Readback: old chain contents with the consumer stalled 3 cycles.
        begin
            int widx, low_cnt, n_got;
            bit got_done;
            logic [1:0][31:0] ws;
            ws = {32'h9900_0000, 32'hCAFE_F00D};
            chain_m = 40'h12_3456_789A;
            rexp_q = {32'h1234_5678, 32'h9A00_0000};
            widx = 0; low_cnt = 0; n_got = 0; en = 0; cyc = 0; got_done = 0;
            start = 1'b1; chain_len = LEN_W'(40); wvalid = 1'b1; wdata = ws[0]; rready = 1'b1;
            while (!got_done && cyc < 80) begin
                @(negedge prog_clk);
                cyc++;
                start = 1'b0;
                if (done) begin
                    got_done = 1;
                    check("rb_done_cycle", cyc, 46);
                    check("rb_en_count", en, 40);
                    check("rb_words_left", rexp_q.size(), 0);
                    check("rb_chain", chain_m, {ws[0], ws[1][31:24]});
                end else begin
                    rready = 1'b1;
                    if (rvalid && n_got == 0 && low_cnt < 3) begin
                        rready = 1'b0;
                        low_cnt++;
                    end
                    wdata = (widx < 2) ? ws[widx] : 32'h0;
                    #1;
                    if (chain_clk_en) en++;
                    if (wvalid && wready) widx++;
                    if (rvalid && rready) begin
                        if (rexp_q.size() == 0) check("rb_extra_word", 1, 0);
                        else check("rb_rdata", rdata, rexp_q.pop_front());
                        n_got++;
                    end
                end
            end
            if (!got_done) check("rb_done_timeout", 0, 1);
            wvalid = 1'b0;
            @(negedge prog_clk);
            check("rb_idle_rvalid", rvalid, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
